ram_sdp_stream_reader_512x32: RTL and testbench
===============================================

Name: ram_sdp_stream_reader_512x32

Overview:
- Read-side engine for the 512x32 simple dual-port RAM.
- Given a start address and length, it drives the RAM read address and absorbs the RAM's fixed 1-cycle registered read latency (the RAM read port has no enable).
- Returned words are streamed on a valid/ready interface with full backpressure support.
- Sits in the RAM read-clock domain; the write side is a separate writer.

Parameters:
- DATA_W, 32, RAM/stream data width
- ADDR_W, 9, RAM address width
- DEPTH, 512, RAM words; addresses wrap modulo DEPTH
- LEN_W, 10, width of length field (0..512)

Ports:
- clock  in  1  read-domain clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- start_addr  in  ADDR_W  first RAM word to read
- length  in  LEN_W  words to read; 0 = empty transfer; >512 clamped to 512
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after last word handed off
- ram_read_addr  out  ADDR_W  registered address to RAM read port
- ram_dout  in  DATA_W  RAM registered read data, valid 1 cycle after address
- m_valid  out  1  stream data valid
- m_data  out  DATA_W  stream data
- m_last  out  1  qualifies the final word of a transfer
- m_ready  in  1  stream consumer ready
- stall_cycles  out  16  present only with RAM_RD_STALL_CNT_EN

Behaviour:
- Reset values: busy=0, done=0, m_valid=0, m_data=0, m_last=0, ram_read_addr=0, FSM=IDLE, buffer empty, all counters 0. Async reset mid-transfer aborts with no done pulse and no further m_valid.
- FSM IDLE -> READ -> DRAIN -> IDLE:
  - IDLE: start=1 with effective length L>0 latches addr and L; busy=1 next cycle; -> READ.
  - IDLE: start=1 with L=0 gives a done pulse next cycle; busy stays 0; no data.
  - READ: issue one read per cycle when (buffer occupancy + in-flight) < 4. Each issue registers ram_read_addr, then the address increments modulo 512 (511 -> 0). After the L-th issue -> DRAIN.
  - DRAIN: when buffer empty, in-flight=0 and the last handshake has completed, pulse done and drop busy in the same cycle; -> IDLE.
- start is ignored while busy.
- Read pipeline:
  - Address registered at edge N; ram_dout valid after edge N+1; word written into the 4-entry buffer at edge N+2.
  - In-flight counter tracks issued-but-not-captured reads (0..2).
- Latency: start sampled at edge S; ram_read_addr=start_addr after S; m_valid=1 after edge S+3.
- Throughput: with m_ready held 1, one word per cycle sustained.
- Handshake:
  - A transfer occurs on m_valid & m_ready.
  - m_data and m_last are held stable while m_valid=1 and m_ready=0.
  - m_valid never drops without a handshake.
- m_last is 1 only on the L-th word. The tag is stored alongside the data in the buffer.
- Buffer full plus simultaneous pop and push in the same cycle is legal; occupancy is unchanged.
- The credit check uses occupancy before the pop (conservative). No overflow is possible.

Optional Feature:
- Macro RAM_RD_STALL_CNT_EN.
- Defined:
  - stall_cycles port exists: 16-bit count of cycles with busy & m_valid & !m_ready.
  - Saturates at 0xFFFF; cleared on accepted start; reset value 0; holds its value after done.
- Undefined: no port and no counter logic. All other behaviour is identical.

Decomposition:
- Package ram_rd_pkg:
  - DATA_W, ADDR_W, DEPTH, LEN_W, BUF_DEPTH=4 constants.
  - FSM state typedef {IDLE, READ, DRAIN}.
  - Buffer entry struct {last, data}.
- Sub-module ram_rd_skid_fifo:
  - 4-entry synchronous FIFO of {last, data}.
  - Outputs push/pop/occupancy; same clock/reset.
  - Top holds the FSM, address/length counters and in-flight counter.

Test Plan:
- Basic: RAM[k]=k+0x100; start_addr=0x010, L=4, m_ready=1 -> m_data 0x110,0x111,0x112,0x113 on 4 consecutive cycles starting 3 edges after start; m_last on 0x113; done one cycle later.
- Wrap: start_addr=0x1FE, L=4 -> addresses 0x1FE,0x1FF,0x000,0x001; data order matches; m_last on 4th word.
- Backpressure: L=16, m_ready toggled 1/0 randomly -> all 16 words in order, none duplicated or lost. m_data stable while stalled. Never more than 4 words outstanding.
- Boundaries:
  - L=0 -> done pulse, no m_valid, busy stays 0.
  - L=600 -> exactly 512 words.
  - start while busy -> ignored.
- Reset: assert reset mid-transfer after word 5 of 10 -> all outputs return to reset values at once. No done pulse. A new start with L=2 then works normally.
- With RAM_RD_STALL_CNT_EN: L=8, m_ready low for 7 cycles while m_valid=1 -> stall_cycles=7 after done. The next start clears it to 0.

Source files
------------

// File: rtl/ram_rd_pkg.sv
// rtl/ram_rd_pkg.sv - shared constants, FSM state and buffer entry types for the RAM stream reader
package ram_rd_pkg;

   localparam int DATA_W    = 32;
   localparam int ADDR_W    = 9;
   localparam int DEPTH     = 512;
   localparam int LEN_W     = 10;
   localparam int BUF_DEPTH = 4;
   localparam int CNT_W     = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic              last;
      logic [DATA_W-1:0] data;
   } entry_t;

   // Requests longer than the whole RAM are trimmed to one full pass.
   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
      return (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;
   endfunction

endpackage

// File: rtl/ram_rd_skid_fifo.sv
// rtl/ram_rd_skid_fifo.sv - 4-entry synchronous FIFO holding returned words and their last tag
module ram_rd_skid_fifo
   import ram_rd_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  entry_t           push_entry,
   input  logic             pop,
   output entry_t           head,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   entry_t     mem [BUF_DEPTH];
   logic [1:0] wr_ptr;
   logic [1:0] rd_ptr;

   // Storage and pointers; entries are cleared on reset so the head reads zero afterwards.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_entry;
            wr_ptr      <= wr_ptr + 2'd1;
         end
         if (pop) rd_ptr <= rd_ptr + 2'd1;
         // Simultaneous push and pop on a full buffer leaves occupancy unchanged.
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // The head entry is presented directly so the stream sees it without an extra stage.
   always_comb begin
      head  = mem[rd_ptr];
      empty = (count == '0);
   end

endmodule

// File: rtl/ram_sdp_stream_reader_512x32.sv
// rtl/ram_sdp_stream_reader_512x32.sv - RAM read engine streaming words with backpressure; optional RAM_RD_STALL_CNT_EN stall counter
module ram_sdp_stream_reader_512x32
   import ram_rd_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [LEN_W-1:0]  length,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] ram_read_addr,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   input  logic              m_ready
`ifdef RAM_RD_STALL_CNT_EN
   ,
   output logic [15:0]       stall_cycles
`endif
);

   state_t            state;
   state_t            state_n;
   logic              busy_n;
   logic              done_n;
   logic [ADDR_W-1:0] addr_q;
   logic [LEN_W-1:0]  remain;
   logic [LEN_W-1:0]  eff_len;
   logic [1:0]        in_flight;
   logic              issue_d1;
   logic              issue_d2;
   logic              last_d1;
   logic              last_d2;
   logic              accept;
   logic              issue;
   logic              pop;
   logic              drain_done;
   entry_t            head;
   logic              empty;
   logic [CNT_W-1:0]  count;

   // Issue, handshake and completion conditions; credit uses occupancy before this cycle's pop.
   always_comb begin
      eff_len    = clamp_len(length);
      accept     = (state == IDLE) && start && (eff_len != '0);
      issue      = (state == READ) &&
                   ((4'(count) + 4'(in_flight)) < 4'(BUF_DEPTH));
      pop        = m_valid && m_ready;
      drain_done = (state == DRAIN) && (in_flight == 2'd0) &&
                   ((count == '0) || ((count == CNT_W'(1)) && pop));
      m_valid    = !empty;
      m_data     = head.data;
      m_last     = !empty && head.last;
   end

   // Next-state, busy and done decisions.
   always_comb begin
      state_n = state;
      done_n  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (eff_len != '0) state_n = READ;
               else               done_n  = 1'b1;
            end
         end
         READ: begin
            if (issue && (remain == LEN_W'(1))) state_n = DRAIN;
         end
         DRAIN: begin
            if (drain_done) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
      busy_n = (state_n != IDLE);
   end

   // State register with registered busy/done outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         busy  <= busy_n;
         done  <= done_n;
      end
   end

   // Address/length counters and the two-stage read-return tracker.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ram_read_addr <= '0;
         addr_q        <= '0;
         remain        <= '0;
         issue_d1      <= 1'b0;
         issue_d2      <= 1'b0;
         last_d1       <= 1'b0;
         last_d2       <= 1'b0;
         in_flight     <= '0;
      end else begin
         if (accept) begin
            // Preload the RAM address so the first issue simply re-registers it.
            ram_read_addr <= start_addr;
            addr_q        <= start_addr;
            remain        <= eff_len;
         end else if (issue) begin
            ram_read_addr <= addr_q;
            // ADDR_W bits cover exactly DEPTH words, so natural overflow gives 511 -> 0.
            addr_q        <= addr_q + 1'b1;
            remain        <= remain - 1'b1;
         end
         issue_d1  <= issue;
         last_d1   <= issue && (remain == LEN_W'(1));
         issue_d2  <= issue_d1;
         last_d2   <= last_d1;
         in_flight <= in_flight + 2'(issue) - 2'(issue_d2);
      end
   end

`ifdef RAM_RD_STALL_CNT_EN
   // Saturating count of cycles the consumer held off a valid word during a transfer.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stall_cycles <= '0;
      end else if (accept) begin
         stall_cycles <= '0;
      end else if (busy && m_valid && !m_ready && (stall_cycles != 16'hFFFF)) begin
         stall_cycles <= stall_cycles + 16'd1;
      end
   end
`endif

   ram_rd_skid_fifo u_fifo (
      .clock      (clock),
      .reset      (reset),
      .push       (issue_d2),
      .push_entry ('{last: last_d2, data: ram_dout}),
      .pop        (pop),
      .head       (head),
      .empty      (empty),
      .count      (count)
   );

endmodule

// File: tb/tb_ram_sdp_stream_reader_512x32.sv
// tb/tb_ram_sdp_stream_reader_512x32.sv - directed self-checking bench for the RAM stream reader
module tb_ram_sdp_stream_reader_512x32;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [8:0]  start_addr = '0;
   logic [9:0]  length = '0;
   logic        busy;
   logic        done;
   logic [8:0]  ram_read_addr;
   logic [31:0] ram_dout = '0;
   logic        m_valid;
   logic [31:0] m_data;
   logic        m_last;
   logic        m_ready = 1'b0;
`ifdef RAM_RD_STALL_CNT_EN
   logic [15:0] stall_cycles;
`endif

   logic [31:0] mem [512];
   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   // RAM model: registered read, no enable, one cycle latency.
   always @(posedge clock) ram_dout <= mem[ram_read_addr];

   ram_sdp_stream_reader_512x32 dut (
      .clock         (clock),
      .reset         (reset),
      .start         (start),
      .start_addr    (start_addr),
      .length        (length),
      .busy          (busy),
      .done          (done),
      .ram_read_addr (ram_read_addr),
      .ram_dout      (ram_dout),
      .m_valid       (m_valid),
      .m_data        (m_data),
      .m_last        (m_last),
      .m_ready       (m_ready)
`ifdef RAM_RD_STALL_CNT_EN
      ,
      .stall_cycles  (stall_cycles)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Pulse start for one posedge; returns at the negedge after the sampling edge.
   task automatic do_start(input logic [8:0] a, input logic [9:0] len);
      @(negedge clock);
      start      = 1'b1;
      start_addr = a;
      length     = len;
      @(negedge clock);
      start = 1'b0;
   endtask

   // Consume a transfer of n words from address a0, checking order, last tag, hold and done.
   task automatic run_stream(input int n, input logic [8:0] a0, input bit random_ready);
      int          got = 0;
      bit          stalled = 0;
      bit          seen_done = 0;
      logic [31:0] held_d = '0;
      logic        held_l = 1'b0;
      logic [8:0]  a;
      for (int cyc = 0; cyc < n * 8 + 50 && !seen_done; cyc++) begin
         m_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (stalled) begin
            check("hold_valid", {31'd0, m_valid}, 32'd1);
            check("hold_data", m_data, held_d);
            check("hold_last", {31'd0, m_last}, {31'd0, held_l});
         end
         if (done) begin
            seen_done = 1;
            check("done_word_count", got, n);
         end else if (m_valid) begin
            if (got >= n) begin
               check("extra_valid", {31'd0, m_valid}, 32'd0);
            end else if (m_ready) begin
               a = a0 + 9'(got);
               check("data", m_data, 32'(a) + 32'h100);
               check("last", {31'd0, m_last}, {31'd0, (got == n - 1)});
               got++;
            end
         end
         stalled = m_valid && !m_ready;
         held_d  = m_data;
         held_l  = m_last;
         if (!seen_done) @(negedge clock);
      end
      check("done_seen", {31'd0, seen_done}, 32'd1);
      check("words", got, n);
      @(negedge clock);
      check("done_width", {31'd0, done}, 32'd0);
      check("busy_after", {31'd0, busy}, 32'd0);
      check("valid_after", {31'd0, m_valid}, 32'd0);
   endtask

   initial begin
      int got;
      for (int k = 0; k < 512; k++) mem[k] = 32'(k) + 32'h100;

      // Reset state
      repeat (3) @(negedge clock);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_valid", {31'd0, m_valid}, 32'd0);
      check("rst_data", m_data, 32'd0);
      check("rst_last", {31'd0, m_last}, 32'd0);
      check("rst_addr", {23'd0, ram_read_addr}, 32'd0);
`ifdef RAM_RD_STALL_CNT_EN
      check("rst_stall", {16'd0, stall_cycles}, 32'd0);
`endif
      reset = 1'b0;

      // Basic, cycle-exact: S edge, then valid from S+3, done right after the last handshake
      m_ready = 1'b1;
      do_start(9'h010, 10'd4);
      check("b_busy", {31'd0, busy}, 32'd1);
      check("b_addr_s", {23'd0, ram_read_addr}, 32'h010);
      check("b_valid_s", {31'd0, m_valid}, 32'd0);
      @(negedge clock);
      check("b_valid_s1", {31'd0, m_valid}, 32'd0);
      check("b_addr_s1", {23'd0, ram_read_addr}, 32'h010);
      @(negedge clock);
      check("b_valid_s2", {31'd0, m_valid}, 32'd0);
      check("b_addr_s2", {23'd0, ram_read_addr}, 32'h011);
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("b_valid", {31'd0, m_valid}, 32'd1);
         check("b_data", m_data, 32'h110 + 32'(i));
         check("b_last", {31'd0, m_last}, {31'd0, (i == 3)});
         check("b_done_early", {31'd0, done}, 32'd0);
      end
      @(negedge clock);
      check("b_done", {31'd0, done}, 32'd1);
      check("b_busy_end", {31'd0, busy}, 32'd0);
      check("b_valid_end", {31'd0, m_valid}, 32'd0);
      @(negedge clock);
      check("b_done_width", {31'd0, done}, 32'd0);

      // Address wrap 0x1FE -> 0x001
      do_start(9'h1FE, 10'd4);
      check("w_addr_s", {23'd0, ram_read_addr}, 32'h1FE);
      @(negedge clock);
      check("w_addr_s1", {23'd0, ram_read_addr}, 32'h1FE);
      @(negedge clock);
      check("w_addr_s2", {23'd0, ram_read_addr}, 32'h1FF);
      @(negedge clock);
      check("w_addr_s3", {23'd0, ram_read_addr}, 32'h000);
      run_stream(4, 9'h1FE, 1'b0);

      // Random backpressure
      m_ready = 1'b0;
      do_start(9'h080, 10'd16);
      run_stream(16, 9'h080, 1'b1);

      // Zero length: done pulse only
      do_start(9'h050, 10'd0);
      check("z_done", {31'd0, done}, 32'd1);
      check("z_busy", {31'd0, busy}, 32'd0);
      check("z_valid", {31'd0, m_valid}, 32'd0);
      @(negedge clock);
      check("z_done_width", {31'd0, done}, 32'd0);
      check("z_valid2", {31'd0, m_valid}, 32'd0);

      // Over-long request clamps to 512 words
      m_ready = 1'b1;
      do_start(9'h100, 10'd600);
      run_stream(512, 9'h100, 1'b0);

      // Start while busy is ignored
      m_ready = 1'b0;
      do_start(9'h010, 10'd4);
      @(negedge clock);
      start      = 1'b1;
      start_addr = 9'h100;
      length     = 10'd2;
      @(negedge clock);
      start = 1'b0;
      run_stream(4, 9'h010, 1'b0);
      @(negedge clock);
      check("ib_valid", {31'd0, m_valid}, 32'd0);
      check("ib_busy", {31'd0, busy}, 32'd0);

      // Reset mid-transfer after word 5 of 10
      m_ready = 1'b1;
      do_start(9'h020, 10'd10);
      got = 0;
      for (int c = 0; c < 40 && got < 5; c++) begin
         if (m_valid && m_ready) got++;
         if (got < 5) @(negedge clock);
      end
      check("r_words_before", got, 5);
      @(posedge clock);
      #2 reset = 1'b1;
      #1;
      check("r_busy", {31'd0, busy}, 32'd0);
      check("r_done", {31'd0, done}, 32'd0);
      check("r_valid", {31'd0, m_valid}, 32'd0);
      check("r_data", m_data, 32'd0);
      check("r_last", {31'd0, m_last}, 32'd0);
      check("r_addr", {23'd0, ram_read_addr}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         check("r_no_done", {31'd0, done}, 32'd0);
         check("r_no_valid", {31'd0, m_valid}, 32'd0);
      end
      do_start(9'h030, 10'd2);
      run_stream(2, 9'h030, 1'b0);

`ifdef RAM_RD_STALL_CNT_EN
      // Stall counter: 7 held-off cycles, then cleared by the next start
      m_ready = 1'b0;
      do_start(9'h040, 10'd8);
      for (int c = 0; c < 20 && !m_valid; c++) @(negedge clock);
      check("s_valid_up", {31'd0, m_valid}, 32'd1);
      repeat (7) @(negedge clock);
      run_stream(8, 9'h040, 1'b0);
      check("s_count", {16'd0, stall_cycles}, 32'd7);
      m_ready = 1'b1;
      do_start(9'h060, 10'd2);
      check("s_cleared", {16'd0, stall_cycles}, 32'd0);
      run_stream(2, 9'h060, 1'b0);
      check("s_zero_after", {16'd0, stall_cycles}, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
